// File: rtl/machine_d_pkg.sv
// Shared constants for the machine_d 3-bit up/down counter.
package machine_d_pkg;

  localparam int unsigned W = 3;

  // Counter end points; the wrap flag fires on these.
  localparam logic [W-1:0] ST_ZERO = 3'b000;
  localparam logic [W-1:0] ST_MAX  = 3'b111;

  // Direction encoding carried on input x.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : machine_d_pkg

// File: rtl/machine_d_d_ff.sv
// d_ff: 1-bit rising-edge D flip-flop with no reset of its own.
// Any reset is folded into the D input by the instantiating logic.
// Ports:
//   clk_i : clock
//   d_i   : data in, captured on the rising edge
//   q_o   : registered data out
module d_ff (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  always_ff @(posedge clk_i) begin
    q_o <= d_i;
  end

endmodule : d_ff

// File: rtl/machine_d.sv
// machine_d: 3-bit synchronous up/down counter built from three D flip-flops.
// Ports:
//   CLK   : clock, state changes on its rising edge
//   RESET : synchronous active-low reset (forces S to 000 at the edge)
//   x     : direction, 0 = count up, 1 = count down
//   F     : terminal-count flag, high in the cycle before a wrap (Mealy on x)
//   S     : current counter value, straight from the flip-flops
module machine_d
  import machine_d_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         x,
  output logic         F,
  output logic [W-1:0] S
);

  logic [W-1:0] d_raw;
  logic [W-1:0] d_gated;
  logic         borrow_c;
  logic         carry_c;

  // Bit 2 toggles when the lower bits are about to wrap in the current direction.
  assign borrow_c = ~S[1] & ~S[0];
  assign carry_c  =  S[1] &  S[0];

  // Per-bit next-state equations.
  assign d_raw[0] = ~S[0];
  assign d_raw[1] = S[1] ^ (S[0] ^ x);
  assign d_raw[2] = S[2] ^ (x ? borrow_c : carry_c);

  // Synchronous reset: forcing every D to 0 also blocks any X on x from reaching S.
  assign d_gated = d_raw & {W{RESET}};

  // Wrap-imminent flag follows x combinationally.
  assign F = ((x == DIR_UP)   && (S == ST_MAX)) ||
             ((x == DIR_DOWN) && (S == ST_ZERO));

  d_ff u_ff0 (.clk_i(CLK), .d_i(d_gated[0]), .q_o(S[0]));
  d_ff u_ff1 (.clk_i(CLK), .d_i(d_gated[1]), .q_o(S[1]));
  d_ff u_ff2 (.clk_i(CLK), .d_i(d_gated[2]), .q_o(S[2]));

endmodule : machine_d

// File: tb/tb_machine_d.sv
// Self-checking bench for machine_d: directed scenarios with literal
// expectations, then randomized direction/reset traffic checked every
// cycle against a behavioural counter model.
module tb_machine_d;

  logic       CLK;
  logic       RESET;
  logic       x;
  logic       F;
  logic [2:0] S;

  int n_cmp;
  int n_bad;

  machine_d dut (
    .CLK  (CLK),
    .RESET(RESET),
    .x    (x),
    .F    (F),
    .S    (S)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural model: modular arithmetic on the value, valid after first reset.
  int m_s;
  bit m_valid;

  initial begin
    m_s     = 0;
    m_valid = 1'b0;
  end

  always @(posedge CLK) begin
    if (RESET === 1'b0) begin
      m_s     = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (x) m_s = (m_s + 7) % 8;
      else   m_s = (m_s + 1) % 8;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      int exp_f;
      exp_f = ((x == 1'b0 && m_s == 7) || (x == 1'b1 && m_s == 0)) ? 1 : 0;
      n_cmp++;
      if (int'(S) != m_s) begin
        n_bad++;
        $display("FAIL model_S t=%0t actual=%0d required=%0d", $time, S, m_s);
      end
      n_cmp++;
      if (int'(F) != exp_f) begin
        n_bad++;
        $display("FAIL model_F t=%0t actual=%0d required=%0d", $time, F, exp_f);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RESET = 1'b0;
    x     = 1'b0;

    // Reset with x=0, then x=1 while still in reset.
    tick();
    chk("rst_S", int'(S), 0);
    chk("rst_F_up", int'(F), 0);
    x = 1'b1;
    #1;
    chk("rst_F_down", int'(F), 1);
    tick();
    chk("rst_hold_S", int'(S), 0);

    // Count up through a full wrap.
    RESET = 1'b1;
    x     = 1'b0;
    #1;
    chk("up_F_at0", int'(F), 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("up_S", int'(S), i % 8);
      chk("up_F", int'(F), (i == 7) ? 1 : 0);
    end

    // Count down from zero across the wrap.
    x = 1'b1;
    #1;
    chk("dn_F_at0", int'(F), 1);
    tick(); chk("dn_S7", int'(S), 7); chk("dn_F7", int'(F), 0);
    tick(); chk("dn_S6", int'(S), 6);
    tick(); chk("dn_S5", int'(S), 5);

    // Reach 011, then direction change.
    tick(); tick();
    chk("dir_S3", int'(S), 3);
    tick(); chk("dir_S2", int'(S), 2);
    tick(); chk("dir_S1", int'(S), 1);
    x = 1'b0;
    tick(); chk("dir_S2b", int'(S), 2);

    // Reset mid-operation from 101.
    tick(); tick(); tick();
    chk("mid_S5", int'(S), 5);
    x     = 1'b1;
    RESET = 1'b0;
    tick(); chk("mid_rst_S", int'(S), 0);
    RESET = 1'b1;
    tick(); chk("mid_rel_S", int'(S), 7);

    // RESET glitch between edges must not reset.
    #1 RESET = 1'b0;
    #1 RESET = 1'b1;
    chk("glitch_hold_S", int'(S), 7);
    tick(); chk("glitch_next_S", int'(S), 6);

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 300; i++) begin
      x     = 1'($urandom_range(0, 1));
      RESET = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_machine_d
